// File: rtl/matc_frame_serializer.sv
// Byte-serial framer for 2x2 matrix-multiplier results:
// header, four sign-extended elements, optional XOR checksum.
module matc_frame_serializer #(
    parameter int         ELEM_W      = 5,
    parameter logic [3:0] HDR_TAG     = 4'hA,
    parameter bit         CHECKSUM_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*ELEM_W-1:0] in_c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic                out_last,
    output logic                busy,
    output logic [3:0]          seq
);

    typedef enum logic [2:0] {
        IDLE, HDR, D0, D1, D2, D3, CKS
    } state_t;

    state_t              state, state_nx;
    logic [4*ELEM_W-1:0] cbuf;
    logic                last_beat;
    logic                take;
    logic                adv;
    logic [7:0]          hdr_b, e0, e1, e2, e3, cks_b;

    function automatic logic [7:0] sext(input logic [ELEM_W-1:0] e);
        return 8'(signed'(e));
    endfunction

    assign last_beat = CHECKSUM_EN ? (state == CKS) : (state == D3);
    assign out_valid = (state != IDLE);
    assign busy      = (state != IDLE);
    assign out_last  = last_beat;
    // Only out_ready reaches in_ready combinationally; the rest is state.
    assign in_ready  = (state == IDLE) | (last_beat & out_ready);
    assign take      = in_valid & in_ready;
    assign adv       = out_valid & out_ready;

    assign hdr_b = {HDR_TAG, seq};
    assign e0    = sext(cbuf[0*ELEM_W +: ELEM_W]);
    assign e1    = sext(cbuf[1*ELEM_W +: ELEM_W]);
    assign e2    = sext(cbuf[2*ELEM_W +: ELEM_W]);
    assign e3    = sext(cbuf[3*ELEM_W +: ELEM_W]);
    assign cks_b = hdr_b ^ e0 ^ e1 ^ e2 ^ e3;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (take) state_nx = HDR;
            HDR:  if (adv)  state_nx = D0;
            D0:   if (adv)  state_nx = D1;
            D1:   if (adv)  state_nx = D2;
            D2:   if (adv)  state_nx = D3;
            D3: begin
                if (adv) begin
                    if (CHECKSUM_EN) state_nx = CKS;
                    else             state_nx = take ? HDR : IDLE;
                end
            end
            CKS:  if (adv)  state_nx = take ? HDR : IDLE;
            default:        state_nx = IDLE;
        endcase
    end

    always_comb begin
        out_data = 8'h00;
        unique case (state)
            HDR:     out_data = hdr_b;
            D0:      out_data = e0;
            D1:      out_data = e1;
            D2:      out_data = e2;
            D3:      out_data = e3;
            CKS:     out_data = cks_b;
            default: out_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cbuf  <= '0;
            seq   <= 4'd0;
        end else begin
            state <= state_nx;
            if (take)
                cbuf <= in_c;
            // Header of the finished frame already used the old value.
            if (last_beat && adv)
                seq <= seq + 4'd1;
        end
    end

endmodule

// File: tb/tb_matc_frame_serializer.sv
// Scoreboard bench for matc_frame_serializer, checksum and
// no-checksum builds.
module tb_matc_frame_serializer;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [4*W-1:0] in_c;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;
    logic         busy;
    logic [3:0]   seq;

    logic         rst2;
    logic         in_valid2;
    logic         in_ready2;
    logic [4*W-1:0] in_c2;
    logic         out_valid2;
    logic         out_ready2;
    logic [7:0]   out_data2;
    logic         out_last2;
    logic         busy2;
    logic [3:0]   seq2;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp2_q[$];

    always #5 clk = ~clk;

    matc_frame_serializer #(.ELEM_W(W), .HDR_TAG(4'hA), .CHECKSUM_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .seq(seq)
    );

    matc_frame_serializer #(.ELEM_W(W), .HDR_TAG(4'hA), .CHECKSUM_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_c(in_c2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_last(out_last2),
        .busy(busy2), .seq(seq2)
    );

    function automatic logic [4*W-1:0] pack(input int c00, input int c01,
                                            input int c10, input int c11);
        logic [W-1:0] a, b, c, d;
        a = W'(c00); b = W'(c01); c = W'(c10); d = W'(c11);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitors: pop and compare every consumed beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat: got %0h last=%0b expected none",
                         out_data, out_last);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    failures++;
                    $display("FAIL beat: got %0h last=%0b expected %0h last=%0b",
                             out_data, out_last, e[7:0], e[8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst2 && out_valid2 && out_ready2) begin
            checks++;
            if (exp2_q.size() == 0) begin
                failures++;
                $display("FAIL beat2: got %0h last=%0b expected none",
                         out_data2, out_last2);
            end else begin
                logic [8:0] e;
                e = exp2_q.pop_front();
                if ({out_last2, out_data2} !== e) begin
                    failures++;
                    $display("FAIL beat2: got %0h last=%0b expected %0h last=%0b",
                             out_data2, out_last2, e[7:0], e[8]);
                end
            end
        end
    end

    task automatic push_frame(input logic [7:0] h, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] d3, input logic [7:0] ck);
        exp_q.push_back({1'b0, h});
        exp_q.push_back({1'b0, d0});
        exp_q.push_back({1'b0, d1});
        exp_q.push_back({1'b0, d2});
        exp_q.push_back({1'b0, d3});
        exp_q.push_back({1'b1, ck});
    endtask

    // Offer a matrix until accepted; header must follow one cycle later.
    task automatic send(input logic [4*W-1:0] c, input logic [7:0] hdr);
        bit got;
        got = 1'b0;
        in_c = c;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL capture: got no in_ready expected in_ready within 50 cycles");
        end else begin
            chk("hdr_latency", {out_valid, out_data}, {1'b1, hdr});
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(ok), 32'd1);
    endtask

    task automatic wait_data(input logic [7:0] v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_data == v) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_data", 32'(ok), 32'd1);
    endtask

    localparam logic [4*W-1:0] CA = {5'd8, 5'h1C, 5'h1F, 5'd2};

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        in_valid = 1'b0; in_valid2 = 1'b0;
        in_c = '0; in_c2 = '0;
        out_ready = 1'b1; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst2 = 1'b0;

        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_seq", 32'(seq), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("pack", 32'(pack(2, -1, -4, 8)), 32'(CA));

        // Basic frame
        push_frame(8'hA0, 8'h02, 8'hFF, 8'hFC, 8'h08, 8'hA9);
        send(CA, 8'hA0);
        wait_idle();
        chk("seq_after_1", 32'(seq), 32'd1);
        chk("idle_data", 32'(out_data), 32'h00);

        // Backpressure while on D1
        push_frame(8'hA1, 8'h02, 8'hFF, 8'hFC, 8'h08, 8'hA8);
        send(CA, 8'hA1);
        wait_data(8'hFF);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_data", 32'(out_data), 32'hFF);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        wait_idle();
        chk("seq_after_2", 32'(seq), 32'd2);

        // Back-to-back, second captured on the CKS beat
        push_frame(8'hA2, 8'h02, 8'hFF, 8'hFC, 8'h08, 8'hAB);
        push_frame(8'hA3, 8'h01, 8'h00, 8'hF0, 8'h0F, 8'h5D);
        send(CA, 8'hA2);
        send(pack(1, 0, -16, 15), 8'hA3);
        wait_idle();
        chk("seq_after_b2b", 32'(seq), 32'd4);

        // Reset on D2: only header, D0, D1 are consumed
        exp_q.push_back({1'b0, 8'hA4});
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'hFF});
        send(CA, 8'hA4);
        wait_data(8'hFC);
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_data", 32'(out_data), 32'h00);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_seq", 32'(seq), 32'd0);
        chk("mr_q", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        push_frame(8'hA0, 8'h02, 8'hFF, 8'hFC, 8'h08, 8'hA9);
        send(CA, 8'hA0);
        wait_idle();

        // Wrap: restart from seq 0 and send 17 frames back-to-back
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            logic [3:0] s;
            s = 4'(i);
            push_frame({4'hA, s}, 8'h02, 8'hFF, 8'hFC, 8'h08, 8'hA9 ^ {4'h0, s});
            send(CA, {4'hA, s});
        end
        wait_idle();
        chk("seq_wrap", 32'(seq), 32'd1);

        // No-checksum build
        exp2_q.push_back({1'b0, 8'hA0});
        exp2_q.push_back({1'b0, 8'h02});
        exp2_q.push_back({1'b0, 8'hFF});
        exp2_q.push_back({1'b0, 8'hFC});
        exp2_q.push_back({1'b1, 8'h08});
        in_c2 = CA;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        chk("nc_hdr", {out_valid2, out_data2}, {1'b1, 8'hA0});
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                if (out_data2 == 8'h08) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("nc_reach_d3", 32'(ok), 32'd1);
            chk("nc_d3_last", 32'(out_last2), 32'd1);
            chk("nc_d3_in_ready", 32'(in_ready2), 32'd1);
        end
        @(posedge clk);
        #1;
        chk("nc_idle", 32'(busy2), 32'd0);
        chk("nc_seq", 32'(seq2), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("q_empty", 32'(exp_q.size()), 32'd0);
        chk("q2_empty", 32'(exp2_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
